// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, group propagate/generate type and tree-sizing helpers for the lookahead adder.
package cla_pkg;
  localparam int CLA_GRP = 4;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
  function automatic int clog4(input int w);
    int d;
    int x;
    d = 0;
    x = 1;
    while (x < w) begin
      x = x * CLA_GRP;
      d++;
    end
    return d;
  endfunction
  function automatic int cells_at(input int w, input int lvl);
    int span;
    span = 1;
    for (int i = 0; i <= lvl; i++) span = span * CLA_GRP;
    return (w + span - 1) / span;
  endfunction
endpackage

// File: rtl/cla_lookahead4.sv
// cla_lookahead4: 4-bit carry-lookahead cell producing internal carries and group propagate/generate.
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       grp_p,
  output logic       grp_g
);
  pg_t grp;
  always_comb begin
    grp.p = &p;
    grp.g = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
    c[0]  = g[0] | (p[0] & ci);
    c[1]  = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
    c[2]  = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci);
    c[3]  = grp.g | (grp.p & ci);
  end
  assign grp_p = grp.p;
  assign grp_g = grp.g;
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder/subtractor with flags, tag and valid/ready flow control.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int DEPTH = clog4(WIDTH);

  if ((WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) || TAG_W < 1) begin : g_bad_param
    $error("cla_adder_pipe: WIDTH must be 4/8/16/32/64 and TAG_W >= 1");
  end

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_sum_q, s2_sum_d;
  logic             s1_c0_q, s1_c0_d, s2_cout_q, s2_cout_d, s2_ovf_q, s2_ovf_d, s2_zero_q, s2_zero_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic             s1_en, s2_en, accept, load;
  logic [WIDTH-1:0] bit_p, bit_g, sum;
  logic [WIDTH:0]   carry;

  assign bit_p = s1_a_q ^ s1_b_q;
  assign bit_g = s1_a_q & s1_b_q;

  // Level 0 groups bits; each higher level groups the P/G of the level below, padded with kill (p=0,g=0).
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int N  = cells_at(WIDTH, l);
    localparam int W4 = CLA_GRP * N;
    logic [W4-1:0] pi, gi, cc;
    logic [W4:0]   ci;
    logic [N-1:0]  gp, gg;
    logic          unused_lvl;
    if (l == 0) begin : g_leaf
      assign pi = bit_p;
      assign gi = bit_g;
    end else begin : g_node
      assign pi = W4'(g_lvl[l-1].gp);
      assign gi = W4'(g_lvl[l-1].gg);
    end
    for (genvar k = 0; k < N; k++) begin : g_cell
      cla_lookahead4 u_cell (
        .g    (gi[4*k +: 4]),
        .p    (pi[4*k +: 4]),
        .ci   (ci[4*k]),
        .c    (cc[4*k +: 4]),
        .grp_p(gp[k]),
        .grp_g(gg[k])
      );
      assign ci[4*k+1 +: 3] = cc[4*k +: 3];
    end
    for (genvar k = 0; k <= N; k++) begin : g_cin
      if (l == DEPTH - 1) begin : g_top
        if (k == 0) begin : g_c0
          assign ci[0] = s1_c0_q;
        end else begin : g_co
          assign ci[4*k] = cc[4*k-1];
        end
      end else begin : g_down
        assign ci[4*k] = g_lvl[l+1].ci[k];
      end
    end
    assign unused_lvl = ^{cc, gp, gg, ci};
  end

  assign carry = g_lvl[0].ci;
  assign sum   = bit_p ^ carry[WIDTH-1:0];

  always_comb begin
    s2_en     = out_ready | ~s2_v_q;
    s1_en     = s2_en | ~s1_v_q;
    accept    = in_valid & s1_en;
    load      = s2_en & s1_v_q;
    s1_v_d    = s1_en ? in_valid : s1_v_q;
    s1_a_d    = accept ? in_a : s1_a_q;
    s1_b_d    = accept ? in_b ^ {WIDTH{in_sub}} : s1_b_q;
    s1_c0_d   = accept ? in_cin ^ in_sub : s1_c0_q;
    s1_tag_d  = accept ? in_tag : s1_tag_q;
    s2_v_d    = s2_en ? s1_v_q : s2_v_q;
    s2_sum_d  = load ? sum : s2_sum_q;
    s2_cout_d = load ? carry[WIDTH] : s2_cout_q;
    s2_ovf_d  = load ? carry[WIDTH] ^ carry[WIDTH-1] : s2_ovf_q;
    s2_zero_d = load ? ~|sum : s2_zero_q;
    s2_tag_d  = load ? s1_tag_q : s2_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_c0_q   <= 1'b0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_sum_q  <= '0;
      s2_cout_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_c0_q   <= s1_c0_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_sum_q  <= s2_sum_d;
      s2_cout_q <= s2_cout_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_zero_q <= s2_zero_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_valid = s2_v_q;
  assign out_sum   = s2_sum_q;
  assign out_cout  = s2_cout_q;
  assign out_ovf   = s2_ovf_q;
  assign out_zero  = s2_zero_q;
  assign out_tag   = s2_tag_q;
endmodule
